sipo_deser: RTL and testbench

- Serial-to-parallel deserializer. Sits directly downstream of an MSB-first parallel-to-serial shift stage.
- Collects WIDTH serial bits, MSB first, starting on a frame marker.
- Presents each completed word on a one-entry valid/ready output register.
- Flags aborted (re-synced) words and dropped (overflowed) words.

---
 rtl/sipo_deser.sv | 116 +++++++++++
 tb/tb_sipo_deser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-to-parallel deserializer feeding a one-entry valid/ready output register.
// Latency: word appears WIDTH cycles after its i_frame; a word completing while the output is held is dropped (o_ovf).
// Optional SIPO_DESER_ABORT_CNT_EN adds o_abort_cnt, an 8-bit saturating count of o_abort pulses.
module sipo_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_data,
   input  logic             i_frame,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_abort,
`ifdef SIPO_DESER_ABORT_CNT_EN
   output logic             o_ovf,
   output logic [7:0]       o_abort_cnt
`else
   output logic             o_ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [SW-1:0]    shreg, shreg_nxt;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic             abort_nxt;
   logic             ovf_nxt;

   // Only WIDTH-1 bits need storing: the LSB is taken straight from i_data on completion.
   assign shifted = {shreg, i_data};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      data_nxt  = o_data;
      valid_nxt = o_valid;
      abort_nxt = 1'b0;
      ovf_nxt   = 1'b0;

      if (o_valid && i_ready) begin
         valid_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            if (i_frame) begin
               state_nxt = SHIFT;
               cnt_nxt   = CW'(1);
               shreg_nxt = SW'(i_data);
            end
         end
         SHIFT: begin
            if (i_frame) begin
               abort_nxt = 1'b1;
               cnt_nxt   = CW'(1);
               shreg_nxt = SW'(i_data);
            end else begin
               cnt_nxt   = cnt + CW'(1);
               shreg_nxt = shifted[SW-1:0];
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  // A simultaneous accept frees the register in time for the new word.
                  if (!o_valid || i_ready) begin
                     data_nxt  = shifted;
                     valid_nxt = 1'b1;
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_abort <= 1'b0;
         o_ovf   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         shreg   <= shreg_nxt;
         o_data  <= data_nxt;
         o_valid <= valid_nxt;
         o_abort <= abort_nxt;
         o_ovf   <= ovf_nxt;
      end
   end

`ifdef SIPO_DESER_ABORT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_abort_cnt <= '0;
      end else if (abort_nxt && (o_abort_cnt != 8'hFF)) begin
         o_abort_cnt <= o_abort_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed table-driven bench for sipo_deser (WIDTH=8): per-cycle vectors plus a reset-mid-word sequence.
module tb_sipo_deser;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_data = 1'b0;
   logic             i_frame = 1'b0;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             o_abort;
   logic             o_ovf;
`ifdef SIPO_DESER_ABORT_CNT_EN
   logic [7:0]       o_abort_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       frame;
      logic       data;
      logic       ready;
      logic       ev;
      logic [7:0] ed;
      logic       ea;
      logic       eo;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i_data),
      .i_frame (i_frame),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_abort (o_abort),
`ifdef SIPO_DESER_ABORT_CNT_EN
      .o_ovf   (o_ovf),
      .o_abort_cnt (o_abort_cnt)
`else
      .o_ovf   (o_ovf)
`endif
   );

   task automatic push(input string name, input logic r, input logic f, input logic d,
                       input logic rdy, input logic ev, input logic [7:0] ed,
                       input logic ea, input logic eo);
      vec_t v;
      v.name = name; v.rst = r; v.frame = f; v.data = d; v.ready = rdy;
      v.ev = ev; v.ed = ed; v.ea = ea; v.eo = eo;
      vecs.push_back(v);
   endtask

   // One word, MSB first; expectations given for the bit cycles before the LSB and for the LSB cycle.
   task automatic push_word(input string name, input logic [7:0] w,
                            input logic rdy_mid, input logic rdy_last,
                            input logic ev_mid, input logic [7:0] ed_mid,
                            input logic ev_last, input logic [7:0] ed_last,
                            input logic eo_last, input logic ea_first);
      for (int i = 0; i < 8; i++) begin
         push($sformatf("%s_b%0d", name, i), 1'b0, (i == 0), w[7-i],
              (i == 7) ? rdy_last : rdy_mid,
              (i == 7) ? ev_last : ev_mid,
              (i == 7) ? ed_last : ed_mid,
              (i == 0) ? ea_first : 1'b0,
              (i == 7) ? eo_last : 1'b0);
      end
   endtask

   task automatic cyc(input logic r, input logic f, input logic d, input logic rdy);
      @(negedge clk);
      rst = r; i_frame = f; i_data = d; i_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp4(input string name, input logic ev, input logic [7:0] ed,
                       input logic ea, input logic eo);
      cmp({name, ".valid"}, 32'(o_valid), 32'(ev));
      cmp({name, ".data"},  32'(o_data),  32'(ed));
      cmp({name, ".abort"}, 32'(o_abort), 32'(ea));
      cmp({name, ".ovf"},   32'(o_ovf),   32'(eo));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] w;

      // Reset, then idle with noise on i_data and i_ready high while nothing is valid.
      push("reset", 1, 0, 0, 0, 0, 8'h00, 0, 0);
      push("idle0", 0, 0, 1, 1, 0, 8'h00, 0, 0);
      push("idle1", 0, 0, 1, 1, 0, 8'h00, 0, 0);
      // Single word: valid for exactly one cycle.
      push_word("single", 8'hA5, 1, 1, 0, 8'h00, 1, 8'hA5, 0, 0);
      push("single_end", 0, 0, 0, 1, 0, 8'hA5, 0, 0);
      // Back-to-back with zero gap.
      push_word("b2b0", 8'hA5, 1, 1, 0, 8'hA5, 1, 8'hA5, 0, 0);
      push_word("b2b1", 8'h3C, 1, 1, 0, 8'hA5, 1, 8'h3C, 0, 0);
      push("b2b_end", 0, 0, 0, 1, 0, 8'h3C, 0, 0);
      // Re-sync after four bits of 0xFF.
      push("rs_f",  0, 1, 1, 1, 0, 8'h3C, 0, 0);
      push("rs_b1", 0, 0, 1, 1, 0, 8'h3C, 0, 0);
      push("rs_b2", 0, 0, 1, 1, 0, 8'h3C, 0, 0);
      push("rs_b3", 0, 0, 1, 1, 0, 8'h3C, 0, 0);
      push_word("rs_w", 8'h81, 1, 1, 0, 8'h3C, 1, 8'h81, 0, 1);
      push("rs_end", 0, 0, 0, 1, 0, 8'h81, 0, 0);
      // Overflow: second word dropped while the first is held.
      push_word("ovf0", 8'hA5, 0, 0, 0, 8'h81, 1, 8'hA5, 0, 0);
      push_word("ovf1", 8'h3C, 0, 0, 1, 8'hA5, 1, 8'hA5, 1, 0);
      push("ovf_hold",  0, 0, 0, 0, 1, 8'hA5, 0, 0);
      push("ovf_drain", 0, 0, 0, 1, 0, 8'hA5, 0, 0);
      // Accept on the completion cycle makes room for the new word.
      push_word("acc0", 8'hA5, 0, 0, 0, 8'hA5, 1, 8'hA5, 0, 0);
      push_word("acc1", 8'h3C, 0, 1, 1, 8'hA5, 1, 8'h3C, 0, 0);
      push("acc_end", 0, 0, 0, 1, 0, 8'h3C, 0, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         cyc(vecs[k].rst, vecs[k].frame, vecs[k].data, vecs[k].ready);
         cmp4(vecs[k].name, vecs[k].ev, vecs[k].ed, vecs[k].ea, vecs[k].eo);
      end

`ifdef SIPO_DESER_ABORT_CNT_EN
      cmp("abort_cnt_one", 32'(o_abort_cnt), 32'd1);
`endif

      // Reset mid-word with a held output word.
      w = 8'h5A;
      for (int i = 0; i < 8; i++) cyc(0, (i == 0), w[7-i], 0);
      cmp4("pre_rst_word", 1, 8'h5A, 0, 0);
      w = 8'hB0;
      for (int i = 0; i < 4; i++) cyc(0, (i == 0), w[7-i], 0);
      cmp4("pre_rst_partial", 1, 8'h5A, 0, 0);
      cyc(1, 1, 1, 0);
      cmp4("rst_mid", 0, 8'h00, 0, 0);
`ifdef SIPO_DESER_ABORT_CNT_EN
      cmp("abort_cnt_rst", 32'(o_abort_cnt), 32'd0);
`endif
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cmp4($sformatf("post_rst%0d", i), 0, 8'h00, 0, 0);
      end
      // Recovery: a clean word after reset.
      w = 8'h0F;
      for (int i = 0; i < 8; i++) cyc(0, (i == 0), w[7-i], 1);
      cmp4("recover_word", 1, 8'h0F, 0, 0);
      cyc(0, 0, 0, 1);
      cmp4("recover_end", 0, 8'h0F, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
